// File: rtl/ext_code_sequencer_pkg.sv
// Shared widths, FSM encodings and run-configuration type for the external-code sequencer.
package ext_code_sequencer_pkg;

  localparam int AW        = 8;
  localparam int DW        = 32;
  localparam int CW        = 16;
  localparam int MIN_DWELL = 3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef struct packed {
    logic [AW-1:0] start;
    logic [AW-1:0] stop;
    logic [CW-1:0] dwell;
    logic [7:0]    loops;
    logic          mode;
  } run_cfg_t;

  // Dwell values below the floor are raised so the prefetch always has time to land.
  function automatic logic [CW-1:0] eff_dwell(input logic [CW-1:0] d);
    return (d < CW'(MIN_DWELL)) ? CW'(MIN_DWELL) : d;
  endfunction

endpackage

// File: rtl/ext_code_sequencer_if.sv
// Host-side bus of the sequencer: table write port, run control, trigger and code outputs.
interface ext_code_sequencer_if;
  import ext_code_sequencer_pkg::*;

  // All strobes (iWR_EN, iStart, iAbort, oStep, oDone) are single-cycle, sampled on the
  // rising clock edge, with no back-pressure: a write is always taken, iStart is taken only
  // in IDLE, iAbort wins over iStart, and oStep/oDone are one-cycle qualifiers for oCode/oIndex.
  logic          iWR_EN;
  logic [AW-1:0] iWR_ADDR;
  logic [DW-1:0] iWR_DATA;
  logic [AW-1:0] iSTART_ADDR;
  logic [AW-1:0] iSTOP_ADDR;
  logic [CW-1:0] iDWELL;
  logic [7:0]    iLOOPS;
  logic          iMODE;
  logic          iStart;
  logic          iAbort;
  logic          iTrigger;
  logic [DW-1:0] oCode;
  logic [AW-1:0] oIndex;
  logic          oBusy;
  logic          oStep;
  logic          oDone;
  logic [2:0]    oState;

  modport master (
    output iWR_EN, iWR_ADDR, iWR_DATA, iSTART_ADDR, iSTOP_ADDR, iDWELL, iLOOPS, iMODE,
           iStart, iAbort, iTrigger,
    input  oCode, oIndex, oBusy, oStep, oDone, oState
  );

  modport slave (
    input  iWR_EN, iWR_ADDR, iWR_DATA, iSTART_ADDR, iSTOP_ADDR, iDWELL, iLOOPS, iMODE,
           iStart, iAbort, iTrigger,
    output oCode, oIndex, oBusy, oStep, oDone, oState
  );

endinterface

// File: rtl/ext_code_sequencer_ram.sv
// Simple dual-port code table: one write port, one registered read-first read port.
module code_table_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_code_sequencer.sv
// Plays a range of the external-code table onto oCode, timed by a dwell counter or by trigger edges.
module ext_code_sequencer
  import ext_code_sequencer_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRst,
  ext_code_sequencer_if.slave  bus
);

  logic [2:0]    state_q, state_d;
  logic          fetch_ph_q, fetch_ph_d;
  logic [AW-1:0] cur_idx_q, cur_idx_d;
  run_cfg_t      cfg_q, cfg_d;
  logic [7:0]    loop_cnt_q, loop_cnt_d;
  logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic          trig_q;
  logic [DW-1:0] code_q, code_d;
  logic [AW-1:0] index_q, index_d;
  logic          step_q, step_d;

  logic          at_stop;
  logic [7:0]    loop_nxt;
  logic          last_entry;
  logic [AW-1:0] next_idx;
  logic          trig_rise;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  code_table_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk_i   (iClk),
    .we_i    (bus.iWR_EN),
    .waddr_i (bus.iWR_ADDR),
    .wdata_i (bus.iWR_DATA),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    at_stop    = (cur_idx_q == cfg_q.stop);
    loop_nxt   = loop_cnt_q + 8'd1;
    last_entry = at_stop && (cfg_q.loops != 8'd0) && (loop_nxt == cfg_q.loops);
    next_idx   = at_stop ? cfg_q.start : cur_idx_q + AW'(1);
    trig_rise  = bus.iTrigger && !trig_q;
    // While holding, the read port keeps fetching the successor so it is ready at the dwell boundary.
    rd_addr    = (state_q == ST_HOLD) ? next_idx : cur_idx_q;
  end

  always_comb begin
    state_d     = state_q;
    fetch_ph_d  = fetch_ph_q;
    cur_idx_d   = cur_idx_q;
    cfg_d       = cfg_q;
    loop_cnt_d  = loop_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    code_d      = code_q;
    index_d     = index_q;
    step_d      = 1'b0;

    if (bus.iAbort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            cfg_d.start = bus.iSTART_ADDR;
            cfg_d.stop  = bus.iSTOP_ADDR;
            cfg_d.dwell = eff_dwell(bus.iDWELL);
            cfg_d.loops = bus.iLOOPS;
            cfg_d.mode  = bus.iMODE;
            cur_idx_d   = bus.iSTART_ADDR;
            loop_cnt_d  = 8'd0;
            fetch_ph_d  = 1'b0;
            state_d     = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!fetch_ph_q) begin
            fetch_ph_d = 1'b1;
          end else begin
            fetch_ph_d  = 1'b0;
            code_d      = rd_data;
            index_d     = cur_idx_q;
            step_d      = 1'b1;
            dwell_cnt_d = cfg_q.dwell;
            state_d     = cfg_q.mode ? ST_WAIT_TRIG : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dwell_cnt_q == CW'(1)) begin
            if (last_entry) begin
              state_d = ST_DONE;
            end else begin
              cur_idx_d   = next_idx;
              loop_cnt_d  = at_stop ? loop_nxt : loop_cnt_q;
              code_d      = rd_data;
              index_d     = next_idx;
              step_d      = 1'b1;
              dwell_cnt_d = cfg_q.dwell;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - CW'(1);
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_rise) begin
            if (last_entry) begin
              state_d = ST_DONE;
            end else begin
              cur_idx_d  = next_idx;
              loop_cnt_d = at_stop ? loop_nxt : loop_cnt_q;
              fetch_ph_d = 1'b0;
              state_d    = ST_FETCH;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      fetch_ph_q  <= 1'b0;
      cur_idx_q   <= '0;
      cfg_q       <= '0;
      loop_cnt_q  <= 8'd0;
      dwell_cnt_q <= '0;
      trig_q      <= 1'b0;
      code_q      <= '0;
      index_q     <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ph_q  <= fetch_ph_d;
      cur_idx_q   <= cur_idx_d;
      cfg_q       <= cfg_d;
      loop_cnt_q  <= loop_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      trig_q      <= bus.iTrigger;
      code_q      <= code_d;
      index_q     <= index_d;
      step_q      <= step_d;
    end
  end

  assign bus.oCode  = code_q;
  assign bus.oIndex = index_q;
  assign bus.oStep  = step_q;
  assign bus.oBusy  = (state_q == ST_FETCH) || (state_q == ST_HOLD) || (state_q == ST_WAIT_TRIG);
  assign bus.oDone  = (state_q == ST_DONE);
  assign bus.oState = state_q;

endmodule

// File: tb/tb_ext_code_sequencer.sv
// Scoreboard bench for ext_code_sequencer: expected step/done events are queued at stimulus time.
module tb_ext_code_sequencer;
  import ext_code_sequencer_pkg::*;

  localparam int EW = 41;  // {done, index[7:0], cycle[31:0]}

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  logic [31:0] m_tab  [256];
  logic [31:0] m_prev [256];
  int          m_wcyc [256];

  int m1_start, m1_len, m1_total, m1_k;

  ext_code_sequencer_if bus ();

  ext_code_sequencer dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic d, input int idx, input int c);
    return {d, 8'(idx), 32'(c)};
  endfunction

  // A step at cycle s shows the table value as read at edge s-1; a write on that edge is not seen.
  function automatic logic [31:0] mdl_code(input logic [7:0] idx, input int s);
    if (m_wcyc[idx] >= s - 1) return m_prev[idx];
    return m_tab[idx];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && (bus.oStep || bus.oDone)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: step=%0b done=%0b idx=%0d code=%0h at cycle %0d, none expected",
                 bus.oStep, bus.oDone, bus.oIndex, bus.oCode, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind_done", 64'(bus.oDone), 64'(mon_e[40]));
        chk("event_cycle", 64'(cyc), 64'(mon_e[31:0]));
        if (!mon_e[40]) begin
          chk("step_index", 64'(bus.oIndex), 64'(mon_e[39:32]));
          chk("step_code", 64'(bus.oCode), 64'(mdl_code(mon_e[39:32], int'(mon_e[31:0]))));
          chk("busy_during_step", 64'(bus.oBusy), 64'd1);
        end else begin
          chk("busy_at_done", 64'(bus.oBusy), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_to(input int e);
    while (cyc + 1 < e) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.iWR_EN   = 1'b1;
    bus.iWR_ADDR = a;
    bus.iWR_DATA = d;
    m_prev[a] = m_tab[a];
    m_tab[a]  = d;
    m_wcyc[a] = cyc + 1;
    @(negedge clk);
    bus.iWR_EN = 1'b0;
  endtask

  // Timed run: entry k of the run is start + (k mod len), spaced max(dwell,3) from the first at s+2.
  task automatic push_run0(input int st, input int sp, input int dw, input int lp, input int s,
                           input int limit);
    int len, total, eff, t;
    len   = ((sp - st) & 255) + 1;
    total = (lp == 0) ? 1_000_000 : lp * len;
    eff   = (dw < MIN_DWELL) ? MIN_DWELL : dw;
    t     = s + 2;
    for (int k = 0; k < total && t < limit; k++) begin
      exp_q.push_back(mk(1'b0, (st + k % len) & 255, t));
      t += eff;
    end
    if (lp != 0 && t < limit) exp_q.push_back(mk(1'b1, 0, t));
  endtask

  task automatic start_run(input int st, input int sp, input int dw, input int lp, input logic md,
                           input int limit_rel, output int s);
    bus.iSTART_ADDR = 8'(st);
    bus.iSTOP_ADDR  = 8'(sp);
    bus.iDWELL      = 16'(dw);
    bus.iLOOPS      = 8'(lp);
    bus.iMODE       = md;
    bus.iStart      = 1'b1;
    s = cyc + 1;
    if (!md) begin
      push_run0(st, sp, dw, lp, s, s + limit_rel);
    end else begin
      m1_start = st;
      m1_len   = ((sp - st) & 255) + 1;
      m1_total = lp * m1_len;
      m1_k     = 0;
      exp_q.push_back(mk(1'b0, st, s + 2));
    end
    @(negedge clk);
    bus.iStart      = 1'b0;
    bus.iSTART_ADDR = 8'($urandom);
    bus.iSTOP_ADDR  = 8'($urandom);
    bus.iDWELL      = 16'($urandom);
    bus.iLOOPS      = 8'($urandom);
    bus.iMODE       = 1'($urandom);
  endtask

  task automatic trig(input int hold);
    int t;
    bus.iTrigger = 1'b1;
    t = cyc + 1;
    m1_k++;
    if (m1_k < m1_total) exp_q.push_back(mk(1'b0, (m1_start + m1_k % m1_len) & 255, t + 2));
    else                 exp_q.push_back(mk(1'b1, 0, t));
    repeat (hold) @(negedge clk);
    bus.iTrigger = 1'b0;
  endtask

  task automatic pulse_abort(input logic with_start);
    bus.iAbort = 1'b1;
    bus.iStart = with_start;
    @(negedge clk);
    bus.iAbort = 1'b0;
    bus.iStart = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, t, st, sp, dw, lp;
    logic [31:0] frz;

    rst = 1'b1;
    bus.iWR_EN = 0; bus.iWR_ADDR = 0; bus.iWR_DATA = 0;
    bus.iSTART_ADDR = 0; bus.iSTOP_ADDR = 0; bus.iDWELL = 0; bus.iLOOPS = 0; bus.iMODE = 0;
    bus.iStart = 0; bus.iAbort = 0; bus.iTrigger = 0;
    for (int i = 0; i < 256; i++) begin
      m_tab[i] = 'x; m_prev[i] = 'x; m_wcyc[i] = -1000;
    end
    repeat (3) @(negedge clk);
    chk("reset_code", 64'(bus.oCode), 64'd0);
    chk("reset_index", 64'(bus.oIndex), 64'd0);
    chk("reset_busy", 64'(bus.oBusy), 64'd0);
    chk("reset_step", 64'(bus.oStep), 64'd0);
    chk("reset_done", 64'(bus.oDone), 64'd0);
    chk("reset_state", 64'(bus.oState), 64'(ST_IDLE));
    rst = 1'b0;

    for (int k = 0; k < 256; k++) wr(8'(k), 32'hC0DE_0000 + 32'(k));

    // Run 1 with mid-run writes: 5 is rewritten early, 6 on the very edge it is fetched again.
    start_run(4, 6, 10, 2, 1'b0, 1_000_000, s);
    wait_to(s + 20); wr(8'd5, 32'hDEAD_BEEF);
    wait_to(s + 30); bus.iStart = 1'b1; @(negedge clk); bus.iStart = 1'b0;
    wait_to(s + 51); wr(8'd6, 32'h1234_5678);
    wait_to(s + 66);
    chk("run1_drained", 64'(exp_q.size()), 64'd0);
    chk("run1_busy_after", 64'(bus.oBusy), 64'd0);

    // Wrapping range, then the same range with a dwell under the floor.
    start_run(254, 1, 3, 1, 1'b0, 1_000_000, s);
    wait_to(s + 2 + 4 * 3 + 3);
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);
    start_run(254, 1, 1, 1, 1'b0, 1_000_000, s);
    wait_to(s + 2 + 4 * 3 + 3);
    chk("min_dwell_drained", 64'(exp_q.size()), 64'd0);

    // Triggered mode: a level held for 10 clocks is one edge.
    start_run(0, 2, 0, 1, 1'b1, 0, s);
    wait_to(s + 20); trig(1);
    wait_to(s + 40); trig(10);
    wait_to(s + 60); trig(1);
    wait_to(s + 64);
    chk("trig_drained", 64'(exp_q.size()), 64'd0);

    // Endless run aborted at edge s+38; the last step (k=7) came at s+37.
    start_run(10, 12, 5, 0, 1'b0, 38, s);
    wait_to(s + 38);
    pulse_abort(1'b0);
    chk("abort_busy", 64'(bus.oBusy), 64'd0);
    frz = m_tab[8'(10 + ((38 - 2 - 1) / 5) % 3)];
    repeat (10) @(negedge clk);
    chk("abort_code_frozen", 64'(bus.oCode), 64'(frz));
    chk("abort_drained", 64'(exp_q.size()), 64'd0);
    pulse_abort(1'b1);
    chk("start_abort_idle", 64'(bus.oState), 64'(ST_IDLE));
    repeat (5) @(negedge clk);
    chk("start_abort_busy", 64'(bus.oBusy), 64'd0);

    // Reset in the middle of the second entry's hold.
    start_run(20, 22, 8, 1, 1'b0, 15, s);
    wait_to(s + 15);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_code", 64'(bus.oCode), 64'd0);
    chk("midrst_index", 64'(bus.oIndex), 64'd0);
    chk("midrst_busy", 64'(bus.oBusy), 64'd0);
    chk("midrst_step", 64'(bus.oStep), 64'd0);
    chk("midrst_state", 64'(bus.oState), 64'(ST_IDLE));
    rst = 1'b0;
    chk("midrst_drained", 64'(exp_q.size()), 64'd0);
    start_run(20, 22, 3, 1, 1'b0, 1_000_000, s);
    wait_to(s + 2 + 3 * 3 + 3);
    chk("after_rst_drained", 64'(exp_q.size()), 64'd0);

    // Randomized timed and triggered runs over a partly rewritten table.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 6; w++) wr(8'($urandom), $urandom);
      st = $urandom_range(0, 255);
      sp = (st + $urandom_range(0, 4)) & 255;
      dw = $urandom_range(0, 7);
      lp = $urandom_range(1, 3);
      start_run(st, sp, dw, lp, 1'b0, 1_000_000, s);
      wait_to(s + 2 + lp * (((sp - st) & 255) + 1) * ((dw < 3) ? 3 : dw) + 3);
      chk("rand0_drained", 64'(exp_q.size()), 64'd0);

      st = $urandom_range(0, 255);
      sp = (st + $urandom_range(0, 2)) & 255;
      lp = $urandom_range(1, 2);
      start_run(st, sp, 0, lp, 1'b1, 0, s);
      t = s + 2 + $urandom_range(4, 10);
      for (int j = 0; j < lp * (((sp - st) & 255) + 1); j++) begin
        wait_to(t);
        trig(1);
        t = t + 2 + $urandom_range(4, 10);
      end
      repeat (4) @(negedge clk);
      chk("rand1_drained", 64'(exp_q.size()), 64'd0);
      chk("rand1_idle", 64'(bus.oState), 64'(ST_IDLE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
